// File: rtl/idex_stage_if.sv
// idex_stage_if: decode-to-execute bundle; master drives D-stage/M-stage inputs, slave (idex_stage) drives E-stage regs and stalls
interface idex_stage_if;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, FlushE;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        MemtoRegM;
  logic [4:0]  WriteRegM;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;
  logic        StallF, StallD;
  logic [15:0] StallCount;
  modport slave (
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, FlushE, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, MemtoRegM, WriteRegM,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, StallF, StallD, StallCount
  );
  modport master (
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, FlushE, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, MemtoRegM, WriteRegM,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, StallF, StallD, StallCount
  );
endinterface

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use/branch hazard stall, bubble injection and saturating stall counter; ports clk, reset, idex_stage_if.slave b
module idex_stage (
  input logic         clk,
  input logic         reset,
  idex_stage_if.slave b
);
  logic lwstall, hit_e, hit_m, stall;
  assign b.WriteRegE = b.RegDstE ? b.RdE : b.RtE;
  always_comb begin
    lwstall = b.ValidE & b.MemtoRegE &
              ((b.RtE == b.RsD && b.RsD != 5'd0) | (b.RtE == b.RtD && b.RtD != 5'd0));
    hit_e   = b.ValidE & b.RegWriteE &
              ((b.WriteRegE == b.RsD && b.RsD != 5'd0) | (b.WriteRegE == b.RtD && b.RtD != 5'd0));
    hit_m   = b.MemtoRegM &
              ((b.WriteRegM == b.RsD && b.RsD != 5'd0) | (b.WriteRegM == b.RtD && b.RtD != 5'd0));
    stall   = !reset & (lwstall | (b.BranchD & (hit_e | hit_m)));
  end
  assign b.StallF = stall;
  assign b.StallD = stall;
  // reset and bubble both clear the whole E register
  always_ff @(posedge clk) begin
    if (reset || stall || b.FlushE) begin
      b.RegWriteE   <= 1'b0;
      b.MemtoRegE   <= 1'b0;
      b.MemWriteE   <= 1'b0;
      b.ALUSrcE     <= 1'b0;
      b.RegDstE     <= 1'b0;
      b.ALUControlE <= 3'd0;
      b.RD1E        <= 32'd0;
      b.RD2E        <= 32'd0;
      b.SignImmE    <= 32'd0;
      b.RsE         <= 5'd0;
      b.RtE         <= 5'd0;
      b.RdE         <= 5'd0;
      b.ValidE      <= 1'b0;
    end else begin
      b.RegWriteE   <= b.RegWriteD;
      b.MemtoRegE   <= b.MemtoRegD;
      b.MemWriteE   <= b.MemWriteD;
      b.ALUSrcE     <= b.ALUSrcD;
      b.RegDstE     <= b.RegDstD;
      b.ALUControlE <= b.ALUControlD;
      b.RD1E        <= b.RD1D;
      b.RD2E        <= b.RD2D;
      b.SignImmE    <= b.SignImmD;
      b.RsE         <= b.RsD;
      b.RtE         <= b.RtD;
      b.RdE         <= b.RdD;
      b.ValidE      <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) b.StallCount <= 16'd0;
    else if (stall && b.StallCount != 16'hffff) b.StallCount <= b.StallCount + 16'd1;
  end
endmodule
